thread_regfile: RTL
===================

# thread_regfile

Per-thread register file for one compute core: sixteen 8-bit registers, of which R0–R12 are general purpose and R13–R15 are read-only thread-context registers. It sits directly upstream and downstream of the ALU. During CORE_REQUEST it latches the two source operands onto `rs`/`rt`, which the ALU and LSU consume in later states. During CORE_UPDATE it writes back the ALU result, the LSU load data or an immediate. One instance exists per thread lane.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, 4: value of R14 (blockDim); 8-bit.
- `THREAD_ID`, 0: value of R15 (threadIdx); 8-bit; must be less than THREADS_PER_BLOCK.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: lane active; when low, no register, output or R13 update occurs.
- `core_state` in 3: core FSM state, using `CORE_*` encodings.
- `block_id` in 8: current block index; mirrored into R13.
- `rs_addr`, `rt_addr` in 4 each: source register indices.
- `rd_addr` in 4: destination register index.
- `reg_write_en` in 1: instruction writes rd.
- `reg_input_mux` in 2: write-data source. 00 = ALU, 01 = LSU, 10 = immediate, 11 = reserved.
- `alu_out` in 8: ALU result.
- `lsu_out` in 8: load data.
- `immediate` in 8: decoded immediate (CONST).
- `rs`, `rt` out 8 each: registered source operands.

## Operation
- Storage: 16 × 8-bit flops.
- Reset: R0–R13 = 0, R14 = THREADS_PER_BLOCK, R15 = THREAD_ID, `rs` = `rt` = 0. Reset overrides all other behaviour, including a reset asserted mid-instruction in any state.
- R13 update: every enabled cycle, R13 <= `block_id`, regardless of `core_state`.
- Read: when enabled and `core_state == CORE_REQUEST`, `rs` <= R[`rs_addr`] and `rt` <= R[`rt_addr`]. In every other state `rs`/`rt` hold their values.
- Write: when enabled, `core_state == CORE_UPDATE`, `reg_write_en` = 1 and `rd_addr` ≤ 12, R[`rd_addr`] <= the selected source.
  - `rd_addr` of 13–15: the write is silently dropped.
  - `reg_input_mux` = 11: no write.
- Width rules: all data is 8-bit unsigned with no extension or saturation. Sources arrive already truncated by the ALU and LSU.
- Read/write conflict: cannot occur, because reads and writes happen in different states. Same-address read-after-write across instructions is naturally ordered through UPDATE→FETCH→…→REQUEST.
- Undefined `core_state` values: no action.

## Timing
- Read latency: 1 cycle.
  - `rs`/`rt` are valid from the first cycle after the REQUEST cycle and stable until the next REQUEST.
  - The ALU samples them in EXECUTE, at least 2 cycles later.
- Write latency: 1 cycle. The new value is visible in R[rd] in the cycle after UPDATE.
- `alu_out`, `lsu_out` and `immediate` must be stable during the UPDATE cycle. `alu_out` is registered by the ALU in EXECUTE, so it is stable by then.
- No handshake: sequencing is driven entirely by `core_state`.

## Configuration
- `REGFILE_R0_ZERO_EN` defined: R0 is hard-wired to zero.
  - Writes to R0 are dropped.
  - Reads of R0 return 0.
  - R0 storage may be optimised away.
- `REGFILE_R0_ZERO_EN` undefined: R0 is an ordinary general-purpose register.

## Structure
- `defines.vh` (the shared header) holds:
  - the `CORE_*` state encodings: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111;
  - the mux codes `RF_SRC_ALU`/`RF_SRC_LSU`/`RF_SRC_IMM`;
  - the constants `RF_BLOCK_IDX` = 13, `RF_BLOCK_DIM` = 14, `RF_THREAD_IDX` = 15.
- One sub-module, `regfile_wb_mux`: combinational write-data select that also outputs a write-valid bit (low for code 11).

## Test plan
- Reset with THREADS_PER_BLOCK = 4, THREAD_ID = 2, then REQUEST with rs_addr = 14, rt_addr = 15 -> next cycle `rs` = 4, `rt` = 2; all of R0–R13 read back as 0.
- UPDATE, mux = 00, alu_out = 0x5A, rd = 3, then a later REQUEST with rs_addr = 3 -> `rs` = 0x5A.
- UPDATE, mux = 10, immediate = 0x7F, rd = 15, then REQUEST with rs_addr = 15 -> `rs` still equals THREAD_ID (write dropped). Repeat with mux = 11, rd = 4 -> R4 unchanged.
- block_id = 9 while enabled, then REQUEST with rt_addr = 13 -> `rt` = 9. Hold enable low, change block_id to 3, assert REQUEST -> R13 stays 9 and `rt` is unchanged.
- Write R5 = 0x11, then change rs_addr while core_state is WAIT/EXECUTE -> `rs` holds. Assert reset during EXECUTE -> next cycle `rs` = 0 and R5 = 0.
- With `REGFILE_R0_ZERO_EN`: UPDATE, mux = 01, lsu_out = 0xFF, rd = 0, then REQUEST with rs_addr = 0 -> `rs` = 0. Without the macro: `rs` = 0xFF.

Source files
------------

// File: rtl/thread_regfile_pkg.sv
// Shared encodings and constants for the per-thread register file:
// core FSM states, write-back source codes and the read-only context register indices.
package thread_regfile_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned MUX_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [MUX_W-1:0] {
    RF_SRC_ALU  = 2'b00,
    RF_SRC_LSU  = 2'b01,
    RF_SRC_IMM  = 2'b10,
    RF_SRC_RSVD = 2'b11
  } rf_src_e;

  localparam logic [ADDR_W-1:0] RF_BLOCK_IDX  = 4'd13;
  localparam logic [ADDR_W-1:0] RF_BLOCK_DIM  = 4'd14;
  localparam logic [ADDR_W-1:0] RF_THREAD_IDX = 4'd15;

endpackage

// File: rtl/thread_regfile_wb_mux.sv
// Combinational write-back data select; wb_valid_c is low for the reserved source code.
module regfile_wb_mux
  import thread_regfile_pkg::*;
(
  input  logic [MUX_W-1:0]  sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] lsu_out,
  input  logic [DATA_W-1:0] immediate,
  output logic [DATA_W-1:0] wb_data_c,
  output logic              wb_valid_c
);

  always_comb begin
    wb_data_c  = '0;
    wb_valid_c = 1'b0;
    case (rf_src_e'(sel))
      RF_SRC_ALU: begin
        wb_data_c  = alu_out;
        wb_valid_c = 1'b1;
      end
      RF_SRC_LSU: begin
        wb_data_c  = lsu_out;
        wb_valid_c = 1'b1;
      end
      RF_SRC_IMM: begin
        wb_data_c  = immediate;
        wb_valid_c = 1'b1;
      end
      default: begin
        wb_data_c  = '0;
        wb_valid_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/thread_regfile.sv
// Per-thread 16x8 register file: R0-R12 general purpose, R13-R15 read-only thread context.
// Optional feature: define REGFILE_R0_ZERO_EN to hard-wire R0 to zero.
module thread_regfile
  import thread_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] THREADS_PER_BLOCK = 8'd4,
  parameter logic [DATA_W-1:0] THREAD_ID         = 8'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [STATE_W-1:0]  core_state,
  input  logic [DATA_W-1:0]   block_id,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                reg_write_en,
  input  logic [MUX_W-1:0]    reg_input_mux,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   lsu_out,
  input  logic [DATA_W-1:0]   immediate,
  output logic [DATA_W-1:0]   rs,
  output logic [DATA_W-1:0]   rt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wb_data_c;
  logic              wb_valid_c;
  logic [DATA_W-1:0] rs_rd_c;
  logic [DATA_W-1:0] rt_rd_c;
  logic              rd_writable_c;
  logic              wr_fire_c;
  logic              rd_fire_c;

  regfile_wb_mux u_wb_mux (
    .sel        (reg_input_mux),
    .alu_out    (alu_out),
    .lsu_out    (lsu_out),
    .immediate  (immediate),
    .wb_data_c  (wb_data_c),
    .wb_valid_c (wb_valid_c)
  );

  // Context registers (R13 and up) are never targets of an instruction write.
  always_comb begin
    rd_writable_c = (rd_addr < RF_BLOCK_IDX);
`ifdef REGFILE_R0_ZERO_EN
    if (rd_addr == '0) rd_writable_c = 1'b0;
`endif
  end

  always_comb begin
    rs_rd_c = regs[rs_addr];
    rt_rd_c = regs[rt_addr];
`ifdef REGFILE_R0_ZERO_EN
    if (rs_addr == '0) rs_rd_c = '0;
    if (rt_addr == '0) rt_rd_c = '0;
`endif
  end

  assign rd_fire_c = enable && (core_state == CORE_REQUEST);
  assign wr_fire_c = enable && (core_state == CORE_UPDATE) && reg_write_en
                     && wb_valid_c && rd_writable_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs                <= '{default: '0};
      regs[RF_BLOCK_DIM]  <= THREADS_PER_BLOCK;
      regs[RF_THREAD_IDX] <= THREAD_ID;
      rs                  <= '0;
      rt                  <= '0;
    end else if (enable) begin
      regs[RF_BLOCK_IDX] <= block_id;
      if (rd_fire_c) begin
        rs <= rs_rd_c;
        rt <= rt_rd_c;
      end
      if (wr_fire_c) regs[rd_addr] <= wb_data_c;
    end
  end

endmodule
